// File: rtl/sync_symbol_streamer_if.sv
// AXI4-Stream symbol bus between the sync symbol streamer and the FFT stage.
// One 8-bit sample per beat, with a symbol-end marker and a channel-estimation flag.
interface sync_symbol_streamer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/sync_symbol_streamer.sv
// Reads one CP-stripped burst out of the time-sync buffer and streams it as FFT symbols.
// A small skid FIFO absorbs the fixed buffer read latency so back-pressure never loses samples.
module sync_symbol_streamer #(
  parameter int unsigned FFT_POINT  = 64,
  parameter int unsigned NUM_SYM    = 12,
  parameter int unsigned CE_SYM     = 4,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           buff_full,
  input  logic [7:0]                     din,
  output logic [9:0]                     read_ptr,
  sync_symbol_streamer_if.master         m_axis,
  output logic                           done
);

  localparam int unsigned LastAddr = NUM_SYM * FFT_POINT - 1;
  localparam int unsigned PtrW     = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SampW    = (FFT_POINT > 1) ? $clog2(FFT_POINT) : 1;
  localparam int unsigned SymW     = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StStream  = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;
  localparam logic [1:0] StWaitRel = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [9:0]        read_ptr_q, read_ptr_d;
  logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [7:0]        mem_q [SKID_DEPTH];
  logic [PtrW-1:0]   wr_idx_q, wr_idx_d;
  logic [PtrW-1:0]   rd_idx_q, rd_idx_d;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [SampW-1:0]  samp_q, samp_d;
  logic [SymW-1:0]   sym_q, sym_d;
  logic              done_q, done_d;

  logic        issue;
  logic        push;
  logic        pop;
  logic        tvalid;
  logic        samp_end;
  logic        last_beat;
  int unsigned inflight;

  assign tvalid    = (fifo_cnt_q != '0);
  assign pop       = tvalid && m_axis.tready;
  assign push      = vld_sr_q[RD_LAT-1];
  assign samp_end  = (samp_q == SampW'(FFT_POINT - 1));
  assign last_beat = samp_end && (sym_q == SymW'(NUM_SYM - 1));

  // Reads are only issued when every outstanding sample is guaranteed a FIFO slot.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 32'(vld_sr_q[i]);
    end
    issue = (state_q == StStream) && ((32'(fifo_cnt_q) + inflight) < SKID_DEPTH);
  end

  always_comb begin
    state_d    = state_q;
    read_ptr_d = read_ptr_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buff_full) state_d = StStream;
      end
      StStream: begin
        if (issue) begin
          if (read_ptr_q == 10'(LastAddr)) begin
            state_d = StDrain;
          end else begin
            read_ptr_d = read_ptr_q + 10'd1;
          end
        end
      end
      StDrain: begin
        if (pop && last_beat) begin
          state_d = StWaitRel;
          done_d  = 1'b1;
        end
      end
      StWaitRel: begin
        if (!buff_full) begin
          state_d    = StIdle;
          read_ptr_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    vld_sr_d    = vld_sr_q;
    vld_sr_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
  end

  always_comb begin
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      wr_idx_d = (wr_idx_q == PtrW'(SKID_DEPTH - 1)) ? '0 : wr_idx_q + PtrW'(1);
    end
    if (pop) begin
      rd_idx_d = (rd_idx_q == PtrW'(SKID_DEPTH - 1)) ? '0 : rd_idx_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Symbol position of the current FIFO head; advances only on a handshake.
  always_comb begin
    samp_d = samp_q;
    sym_d  = sym_q;
    if (pop) begin
      if (samp_end) begin
        samp_d = '0;
        sym_d  = (sym_q == SymW'(NUM_SYM - 1)) ? '0 : sym_q + SymW'(1);
      end else begin
        samp_d = samp_q + SampW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      read_ptr_q <= '0;
      vld_sr_q   <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      fifo_cnt_q <= '0;
      samp_q     <= '0;
      sym_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_ptr_q <= read_ptr_d;
      vld_sr_q   <= vld_sr_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      fifo_cnt_q <= fifo_cnt_d;
      samp_q     <= samp_d;
      sym_q      <= sym_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head below.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx_q] <= din;
  end

  assign read_ptr      = read_ptr_q;
  assign done          = done_q;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = tvalid ? mem_q[rd_idx_q] : 8'h00;
  assign m_axis.tlast  = tvalid && samp_end;
  assign m_axis.tuser  = tvalid && (sym_q < SymW'(CE_SYM));

endmodule

// File: tb/tb_sync_symbol_streamer.sv
// Self-checking bench: buffer model with din = addr[7:0], scoreboard of expected beats,
// spot-check table on a full-rate burst, and sequences for stall, release and reset cases.
module tb_sync_symbol_streamer;

  localparam int RdLat = 2;
  localparam int Beats = 768;

  logic       clk;
  logic       rst_n;
  logic       buff_full;
  logic [7:0] din;
  logic [9:0] read_ptr;
  logic       done;

  sync_symbol_streamer_if axis_if ();

  sync_symbol_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .buff_full (buff_full),
    .din       (din),
    .read_ptr  (read_ptr),
    .m_axis    (axis_if),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pipe [RdLat];
  always @(posedge clk) begin
    pipe[0] <= read_ptr[7:0];
    for (int k = 1; k < RdLat; k++) pipe[k] <= pipe[k-1];
  end
  assign din = pipe[RdLat-1];

  typedef struct {
    int         beat;
    logic [7:0] data;
    logic       last;
    logic       user;
  } spot_t;

  int n_total = 0;
  int n_bad   = 0;

  logic [9:0] exp_q [$];
  logic [9:0] beat_log [Beats];
  int   beat_idx  = 0;
  int   cyc       = 0;
  int   done_cnt  = 0;
  int   done_cyc  = -1;
  int   first_cyc = -1;
  int   last_cyc  = -1;
  int   max_ptr   = 0;
  int   tready_mode = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_burst();
    for (int i = 0; i < Beats; i++) begin
      logic [7:0] d;
      d = i[7:0];
      exp_q.push_back({(i % 64) == 63, i < 256, d});
    end
    beat_idx = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt != start) break;
    end
    check(done_cnt == start + 1, "done_seen", done_cnt - start, 1);
    check(exp_q.size() == 0, "all_beats_out", exp_q.size(), 0);
    check(beat_idx == Beats, "beat_count", beat_idx, Beats);
    check(done_cyc == last_cyc + 1, "done_after_last", done_cyc - last_cyc, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (tready_mode)
      0:       axis_if.tready = 1'b0;
      1:       axis_if.tready = 1'b1;
      default: axis_if.tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: scoreboard pops, stall stability, done timing.
  logic       prev_stall = 1'b0;
  logic [9:0] prev_vec   = '0;
  initial forever begin
    logic [9:0] cur;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
      continue;
    end
    cur = {axis_if.tlast, axis_if.tuser, axis_if.tdata};
    if (int'(read_ptr) > max_ptr) max_ptr = int'(read_ptr);
    if (prev_stall) begin
      check(axis_if.tvalid && (cur == prev_vec), "stall_stable", int'(cur), int'(prev_vec));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (axis_if.tvalid && axis_if.tready) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "extra_beat", int'(cur), -1);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check(cur == e, "beat_vec", int'(cur), int'(e));
      end
      if (beat_idx == 0) first_cyc = cyc;
      if (beat_idx == Beats - 1) last_cyc = cyc;
      if (beat_idx < Beats) beat_log[beat_idx] = cur;
      beat_idx++;
    end
    prev_stall = axis_if.tvalid && !axis_if.tready;
    prev_vec   = cur;
  end

  initial begin
    spot_t spots [10];
    spots[0] = '{0,   8'd0,   1'b0, 1'b1};
    spots[1] = '{1,   8'd1,   1'b0, 1'b1};
    spots[2] = '{63,  8'd63,  1'b1, 1'b1};
    spots[3] = '{64,  8'd64,  1'b0, 1'b1};
    spots[4] = '{127, 8'd127, 1'b1, 1'b1};
    spots[5] = '{255, 8'd255, 1'b1, 1'b1};
    spots[6] = '{256, 8'd0,   1'b0, 1'b0};
    spots[7] = '{300, 8'd44,  1'b0, 1'b0};
    spots[8] = '{511, 8'd255, 1'b1, 1'b0};
    spots[9] = '{767, 8'd255, 1'b1, 1'b0};

    rst_n          = 1'b0;
    buff_full      = 1'b0;
    axis_if.tready = 1'b0;
    #12;
    check(read_ptr == 10'd0, "rst_read_ptr", int'(read_ptr), 0);
    check(!axis_if.tvalid, "rst_tvalid", int'(axis_if.tvalid), 0);
    check(!axis_if.tlast, "rst_tlast", int'(axis_if.tlast), 0);
    check(!axis_if.tuser, "rst_tuser", int'(axis_if.tuser), 0);
    check(axis_if.tdata == 8'd0, "rst_tdata", int'(axis_if.tdata), 0);
    check(!done, "rst_done", int'(done), 0);
    step();
    rst_n = 1'b1;

    // Start stalled, then random back-pressure for the remainder.
    push_burst();
    tready_mode = 0;
    buff_full   = 1'b1;
    repeat (100) step();
    check(read_ptr <= 10'd4, "stall_read_ptr", int'(read_ptr), 4);
    check(axis_if.tvalid, "stall_tvalid", int'(axis_if.tvalid), 1);
    check(axis_if.tdata == 8'd0, "stall_tdata", int'(axis_if.tdata), 0);
    check(beat_idx == 0, "stall_no_beats", beat_idx, 0);
    tready_mode = 2;
    wait_done(6000);

    // Held buff_full after done must not restart the burst.
    tready_mode = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      check(!axis_if.tvalid && !done, "hold_no_beat", int'({axis_if.tvalid, done}), 0);
    end
    buff_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check(!axis_if.tvalid, "low_no_beat", int'(axis_if.tvalid), 0);
    end
    check(read_ptr == 10'd0, "idle_read_ptr", int'(read_ptr), 0);

    // Full-rate burst: throughput and table spot checks.
    push_burst();
    buff_full = 1'b1;
    wait_done(3000);
    check(last_cyc - first_cyc == Beats - 1, "throughput", last_cyc - first_cyc, Beats - 1);
    for (int i = 0; i < 10; i++) begin
      logic [9:0] e;
      e = {spots[i].last, spots[i].user, spots[i].data};
      check(beat_log[spots[i].beat] == e, $sformatf("spot_%0d", spots[i].beat),
            int'(beat_log[spots[i].beat]), int'(e));
    end

    // Asynchronous reset mid-burst, then a clean restart.
    buff_full = 1'b0;
    repeat (2) step();
    push_burst();
    buff_full = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (beat_idx > 300) break;
      step();
    end
    check(beat_idx > 300, "reach_beat_300", beat_idx, 301);
    #2;
    rst_n = 1'b0;
    #1;
    check(read_ptr == 10'd0, "arst_read_ptr", int'(read_ptr), 0);
    check(!axis_if.tvalid && !axis_if.tlast && !axis_if.tuser, "arst_flags",
          int'({axis_if.tvalid, axis_if.tlast, axis_if.tuser}), 0);
    check(axis_if.tdata == 8'd0, "arst_tdata", int'(axis_if.tdata), 0);
    check(!done, "arst_done", int'(done), 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    #1;
    check(read_ptr == 10'd0, "restart_read_ptr", int'(read_ptr), 0);
    push_burst();
    wait_done(3000);
    check(beat_log[0] == 10'b01_0000_0000, "restart_beat0", int'(beat_log[0]), 256);

    check(max_ptr <= 767, "read_ptr_max", max_ptr, 767);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
